// File: rtl/servo_slew_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : servo_slew_scheduler
//  Purpose  : Decodes PS/2 make/break scan bytes into step-up, step-down and
//             centre commands, holds a clamped target pulse width and ramps
//             the commanded pulse width toward it once per PWM frame at a
//             bounded slew rate. Owns frame timing for the PWM generator.
//  Revision : 1.0  initial release
// ============================================================================
module servo_slew_scheduler #(
    parameter int unsigned FRAME_TICKS = 500000,
    parameter int unsigned MIN_PW      = 25000,
    parameter int unsigned MAX_PW      = 50000,
    parameter int unsigned CENTER_PW   = 37500,
    parameter int unsigned STEP        = 2500,
    parameter int unsigned SLEW        = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scan_byte,
    input  logic        scan_valid,
    output logic [15:0] pulse_width,
    output logic        pw_update,
    output logic        frame_start,
    output logic        moving,
    output logic        at_limit
);

    localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(FRAME_TICKS - 1);
    localparam logic [15:0]      c_min_pw     = 16'(MIN_PW);
    localparam logic [15:0]      c_max_pw     = 16'(MAX_PW);
    localparam logic [15:0]      c_center_pw  = 16'(CENTER_PW);
    localparam logic [15:0]      c_slew       = 16'(SLEW);
    localparam logic [16:0]      c_step17     = 17'(STEP);
    localparam logic [16:0]      c_up_thresh  = 17'(MAX_PW - STEP);
    localparam logic [16:0]      c_dn_thresh  = 17'(MIN_PW + STEP);

    localparam logic [7:0] c_key_break = 8'hF0;
    localparam logic [7:0] c_key_up    = 8'h23;
    localparam logic [7:0] c_key_down  = 8'h1C;
    localparam logic [7:0] c_key_centr = 8'h1B;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BREAK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_start;
    logic [15:0]      r_target;
    logic [15:0]      r_pw;
    logic             r_pw_update;
    logic             r_moving;

    logic             w_frame_tick;
    logic [15:0]      w_target_next;
    logic [15:0]      w_pw_next;
    logic [16:0]      w_t17;
    logic [16:0]      w_up_sum;
    logic [16:0]      w_dn_diff;
    logic [15:0]      w_rise;
    logic [15:0]      w_fall;

    // The slew step lands on the same edge that raises frame_start.
    assign w_frame_tick = (r_cnt == c_cnt_last);
    assign w_t17        = {1'b0, r_target};
    assign w_up_sum     = w_t17 + c_step17;
    assign w_dn_diff    = w_t17 - c_step17;
    assign w_rise       = r_target - r_pw;
    assign w_fall       = r_pw - r_target;

    // Scan-code decoder: make codes move the target, a break prefix swallows the next byte.
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        if (scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    case (scan_byte)
                        c_key_break: w_state_next  = ST_BREAK;
                        c_key_up:    w_target_next = (w_t17 > c_up_thresh) ? c_max_pw : w_up_sum[15:0];
                        c_key_down:  w_target_next = (w_t17 < c_dn_thresh) ? c_min_pw : w_dn_diff[15:0];
                        c_key_centr: w_target_next = c_center_pw;
                        default:     w_state_next  = ST_IDLE;
                    endcase
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Slew toward the current (pre-update) target, only at frame boundaries.
    always_comb begin
        w_pw_next = r_pw;
        if (w_frame_tick) begin
            if (r_pw < r_target) begin
                w_pw_next = (w_rise > c_slew) ? (r_pw + c_slew) : r_target;
            end else if (r_pw > r_target) begin
                w_pw_next = (w_fall > c_slew) ? (r_pw - c_slew) : r_target;
            end
        end
    end

    // Frame counter and registered frame boundary strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_frame_tick ? '0 : (r_cnt + 1'b1);
            r_frame_start <= w_frame_tick;
        end
    end

    // Decoder state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Target and pulse-width registers; reset snaps straight back to centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target    <= c_center_pw;
            r_pw        <= c_center_pw;
            r_pw_update <= 1'b0;
            r_moving    <= 1'b0;
        end else begin
            r_target    <= w_target_next;
            r_pw        <= w_pw_next;
            r_pw_update <= w_frame_tick && (w_pw_next != r_pw);
            r_moving    <= (w_pw_next != w_target_next);
        end
    end

    assign pulse_width = r_pw;
    assign pw_update   = r_pw_update;
    assign frame_start = r_frame_start;
    assign moving      = r_moving;
    assign at_limit    = (r_target == c_min_pw) || (r_target == c_max_pw);

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_slew_scheduler
//  Purpose  : Directed self-checking bench for servo_slew_scheduler with a
//             100-cycle frame; expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_servo_slew_scheduler;

    logic        clk;
    logic        reset;
    logic [7:0]  scan_byte;
    logic        scan_valid;
    logic [15:0] pulse_width;
    logic        pw_update;
    logic        frame_start;
    logic        moving;
    logic        at_limit;

    int n_checks;
    int n_fail;

    servo_slew_scheduler #(
        .FRAME_TICKS (100),
        .MIN_PW      (25000),
        .MAX_PW      (50000),
        .CENTER_PW   (37500),
        .STEP        (2500),
        .SLEW        (500)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_byte   (scan_byte),
        .scan_valid  (scan_valid),
        .pulse_width (pulse_width),
        .pw_update   (pw_update),
        .frame_start (frame_start),
        .moving      (moving),
        .at_limit    (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one scan byte for exactly one cycle.
    task automatic send_key(input logic [7:0] b);
        scan_byte  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
    endtask

    // Advance to the next frame_start cycle, then check the frame's outputs.
    task automatic frame_check(input string tag, input int exp_pw, input bit exp_upd, input bit exp_mov);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_value({tag, "_frame_timeout"}, 32'd0, 32'd1);
        end else begin
            check_value({tag, "_pw"},     32'(pulse_width), 32'(exp_pw));
            check_value({tag, "_update"}, 32'(pw_update),   32'(exp_upd));
            check_value({tag, "_moving"}, 32'(moving),      32'(exp_mov));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        scan_byte  = 8'h00;
        scan_valid = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_pw",     32'(pulse_width), 32'd37500);
        check_value("rst_update", 32'(pw_update),   32'd0);
        check_value("rst_fs",     32'(frame_start), 32'd0);
        check_value("rst_moving", 32'(moving),      32'd0);
        check_value("rst_limit",  32'(at_limit),    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: idle for 1000 cycles, frame_start every 100 cycles
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            check_value("t1_fs",     32'(frame_start), 32'((c % 100) == 0));
            check_value("t1_pw",     32'(pulse_width), 32'd37500);
            check_value("t1_update", 32'(pw_update),   32'd0);
            check_value("t1_moving", 32'(moving),      32'd0);
        end

        // 2: one step up, ramp 37500 -> 40000
        send_key(8'h23);
        check_value("t2_moving", 32'(moving),   32'd1);
        check_value("t2_limit",  32'(at_limit), 32'd0);
        for (int k = 1; k <= 5; k++) frame_check("t2_ramp", 37500 + 500 * k, 1'b1, k != 5);
        frame_check("t2_hold", 40000, 1'b0, 1'b0);

        // 3: make, break-make, E0 F0 1C -> exactly one step (40000 -> 42500)
        send_key(8'h23);
        send_key(8'hF0);
        send_key(8'h23);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h1C);
        check_value("t3_moving", 32'(moving), 32'd1);
        for (int k = 1; k <= 5; k++) frame_check("t3_ramp", 40000 + 500 * k, 1'b1, k != 5);
        frame_check("t3_hold", 42500, 1'b0, 1'b0);

        // 4: eleven ups clamp at 50000, then centre and ramp down
        for (int i = 0; i < 11; i++) send_key(8'h23);
        check_value("t4_limit_hi", 32'(at_limit), 32'd1);
        for (int k = 1; k <= 15; k++) frame_check("t4_up", 42500 + 500 * k, 1'b1, k != 15);
        send_key(8'h1B);
        check_value("t4_limit_ctr",  32'(at_limit), 32'd0);
        check_value("t4_moving_ctr", 32'(moving),   32'd1);
        for (int k = 1; k <= 25; k++) frame_check("t4_down", 50000 - 500 * k, 1'b1, k != 25);
        frame_check("t4_hold", 37500, 1'b0, 1'b0);

        // 5: six downs from centre, clamp at 25000
        for (int i = 1; i <= 6; i++) begin
            send_key(8'h1C);
            check_value("t5_limit", 32'(at_limit), 32'(i >= 5));
        end
        frame_check("t5_first", 37000, 1'b1, 1'b1);
        // Key lands in the slew-step cycle: that step still uses the old target (25000)
        for (int i = 0; i < 99; i++) @(negedge clk);
        send_key(8'h1B);
        check_value("t5_sim_fs",     32'(frame_start), 32'd1);
        check_value("t5_sim_pw",     32'(pulse_width), 32'd36500);
        check_value("t5_sim_update", 32'(pw_update),   32'd1);
        check_value("t5_sim_limit",  32'(at_limit),    32'd0);
        frame_check("t5_newtgt", 37000, 1'b1, 1'b1);

        // 6: target 45000, reset asynchronously at pulse_width 44000
        send_key(8'h23);
        send_key(8'h23);
        send_key(8'h23);
        for (int k = 1; k <= 14; k++) frame_check("t6_ramp", 37000 + 500 * k, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_value("t6_async_pw",     32'(pulse_width), 32'd37500);
        check_value("t6_async_fs",     32'(frame_start), 32'd0);
        check_value("t6_async_update", 32'(pw_update),   32'd0);
        check_value("t6_async_moving", 32'(moving),      32'd0);
        check_value("t6_async_limit",  32'(at_limit),    32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            check_value("t6_fs", 32'(frame_start), 32'(c == 100));
        end
        check_value("t6_pw_after", 32'(pulse_width), 32'd37500);
        check_value("t6_update",   32'(pw_update),   32'd0);
        frame_check("t6_hold", 37500, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
